// File: rtl/riscv_defines.sv
// Shared BTB definitions: table geometry, entry layout and 2-bit counter encodings.
package riscv_defines;

  localparam int BTB_ENTRIES_DEF = 16;
  localparam int BTB_IDX_W       = $clog2(BTB_ENTRIES_DEF);
  // Widest possible tag (4-entry table); narrower tags are zero-extended.
  localparam int BTB_TAG_W_MAX   = 28;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_W_MAX-1:0] tag;
    logic [29:0]              target;
    ctr_e                     ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter step, purely combinational.
module sat_counter2
  import riscv_defines::*;
(
  input  ctr_e ctr_in,
  input  logic taken,
  output ctr_e ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    unique case (ctr_in)
      CTR_SNT: ctr_out = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_out = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_out = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_out = taken ? CTR_ST  : CTR_WT;
      default: ctr_out = ctr_in;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup in fetch,
// update from execute committed at the next rising edge.
module branch_predictor
  import riscv_defines::*;
#(
  parameter int BTB_ENTRIES = 1 << BTB_IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pc_pred,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush_btb
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  ctr_e                   ctr_q    [BTB_ENTRIES];
  ctr_e                   ctr_d    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];
  logic [29:0]            target_d [BTB_ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  btb_entry_t       f_entry;
  logic             f_hit, u_hit;
  ctr_e             u_ctr_next;
  logic             unused_lsbs;

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[31:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];

  assign unused_lsbs = ^{pc_f[1:0], update_pc[1:0], update_target[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not visible yet.
  always_comb begin
    f_entry.valid  = valid_q[f_idx];
    f_entry.tag    = BTB_TAG_W_MAX'(tag_q[f_idx]);
    f_entry.target = target_q[f_idx];
    f_entry.ctr    = ctr_q[f_idx];
  end

  assign f_hit      = f_entry.valid && (f_entry.tag == BTB_TAG_W_MAX'(f_tag));
  assign pred_taken = f_hit && f_entry.ctr[1];
  assign pc_pred    = f_hit ? {f_entry.target, 2'b00} : pc_f + 32'd4;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_in  (ctr_q[u_idx]),
    .taken   (update_taken),
    .ctr_out (u_ctr_next)
  );

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (flush_btb) begin
      valid_d = '0;
    end else if (update_en) begin
      if (u_hit) begin
        ctr_d[u_idx] = u_ctr_next;
        if (update_taken) target_d[u_idx] = update_target[31:2];
      end else if (update_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = update_target[31:2];
        ctr_d[u_idx]    = CTR_WT;
      end
    end
  end

  // NOTE: sequential state uses <= so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // NOTE: tags and targets carry no reset; a cleared valid bit already hides them.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a table model of the BTB rules.
module tb_branch_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f = '0;
  logic        pred_taken;
  logic [31:0] pc_pred;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        flush_btb = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .pred_taken    (pred_taken),
    .pc_pred       (pc_pred),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .flush_btb     (flush_btb)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit          m_valid  [N];
  int unsigned m_tag    [N];
  int unsigned m_target [N];
  int          m_ctr    [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    return m_hit(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_update();
    int unsigned i;
    i = idx_of(update_pc);
    if (flush_btb) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else if (update_en) begin
      if (m_hit(update_pc)) begin
        if (update_taken) begin
          m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = update_target & 32'hFFFF_FFFC;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (update_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(update_pc);
        m_target[i] = update_target & 32'hFFFF_FFFC;
        m_ctr[i]    = 2;
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) if (rst_n) model_update();

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_taken", {31'b0, pred_taken}, {31'b0, m_taken(pc_f)});
      check("cyc_pc_pred", pc_pred, m_pred(pc_f));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    update_en     = 1'b1;
    update_pc     = pc;
    update_taken  = tk;
    update_target = tgt;
    tick();
    update_en = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit tk, input logic [31:0] pred);
    pc_f = pc;
    #1;
    check({name, "_taken"}, {31'b0, pred_taken}, {31'b0, tk});
    check({name, "_pred"}, pc_pred, pred);
  endtask

  initial begin
    int vsum;
    logic [31:0] pool_tag [3];
    pool_tag[0] = 32'h40;
    pool_tag[1] = 32'h41;
    pool_tag[2] = 32'h7F;

    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    look("in_reset", 32'h0000_1000, 1'b0, 32'h0000_1004);
    rst_n = 1'b1;
    tick();

    look("post_reset", 32'h0000_1000, 1'b0, 32'h0000_1004);

    // Same-cycle hazard doubles as the first allocation.
    pc_f          = 32'h0000_1000;
    update_en     = 1'b1;
    update_pc     = 32'h0000_1000;
    update_taken  = 1'b1;
    update_target = 32'h0000_2003;
    #1;
    check("hazard_same_taken", {31'b0, pred_taken}, 32'd0);
    tick();
    update_en = 1'b0;
    look("alloc", 32'h0000_1000, 1'b1, 32'h0000_2000);
    check("pin_ctr_alloc", 32'(m_ctr[0]), 32'd2);

    upd(32'h0000_1000, 1'b0, 32'h0);
    look("hyst_nt1", 32'h0000_1000, 1'b0, 32'h0000_2000);
    upd(32'h0000_1000, 1'b1, 32'h0000_2000);
    upd(32'h0000_1000, 1'b1, 32'h0000_2000);
    look("hyst_t2", 32'h0000_1000, 1'b1, 32'h0000_2000);
    upd(32'h0000_1000, 1'b1, 32'h0000_2000);
    check("pin_ctr_sat", 32'(m_ctr[0]), 32'd3);
    upd(32'h0000_1000, 1'b0, 32'h0);
    look("hyst_nt_a", 32'h0000_1000, 1'b1, 32'h0000_2000);
    upd(32'h0000_1000, 1'b0, 32'h0);
    look("hyst_nt_b", 32'h0000_1000, 1'b0, 32'h0000_2000);

    upd(32'h0000_1041, 1'b1, 32'h0000_3000);
    look("alias_old", 32'h0000_1000, 1'b0, 32'h0000_1004);
    look("alias_new", 32'h0000_1040, 1'b1, 32'h0000_3000);

    flush_btb = 1'b1;
    upd(32'h0000_1100, 1'b1, 32'h0000_4000);
    flush_btb = 1'b0;
    look("flush_new", 32'h0000_1100, 1'b0, 32'h0000_1104);
    look("flush_old", 32'h0000_1040, 1'b0, 32'h0000_1044);
    vsum = 0;
    for (int i = 0; i < N; i++) vsum += int'(m_valid[i]);
    check("pin_flush_empty", 32'(vsum), 32'd0);

    upd(32'h0000_1300, 1'b1, 32'h0000_5000);
    look("realloc", 32'h0000_1300, 1'b1, 32'h0000_5000);

    update_en     = 1'b1;
    update_pc     = 32'h0000_1200;
    update_taken  = 1'b1;
    update_target = 32'h0000_6000;
    #1;
    rst_n = 1'b0;
    look("rst_async", 32'h0000_1300, 1'b0, 32'h0000_1304);
    tick();
    update_en = 1'b0;
    look("rst_noland", 32'h0000_1200, 1'b0, 32'h0000_1204);
    rst_n = 1'b1;
    upd(32'h0000_1500, 1'b1, 32'h0000_7000);
    look("post_rst_upd", 32'h0000_1500, 1'b1, 32'h0000_7000);

    for (int c = 0; c < 3000; c++) begin
      pc_f          = (pool_tag[$urandom_range(0, 2)] << 6) | (32'($urandom_range(0, N - 1)) << 2)
                      | 32'($urandom_range(0, 3));
      update_en     = ($urandom_range(0, 9) < 7);
      update_pc     = (pool_tag[$urandom_range(0, 2)] << 6) | (32'($urandom_range(0, N - 1)) << 2)
                      | 32'($urandom_range(0, 3));
      update_taken  = ($urandom_range(0, 9) < 6);
      update_target = $urandom;
      flush_btb     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    update_en = 1'b0;
    flush_btb = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
